// File: rtl/normalizer_avs_mem_pkg.sv
// Shared definitions for the normalizer Avalon-MM sample-buffer responder
// and the benches that talk to it.
package normalizer_avs_mem_pkg;

  typedef enum logic {
    ST_ACCEPT = 1'b0,
    ST_STALL  = 1'b1
  } state_t;

  localparam logic [31:0] OOR_DATA_DEF = 32'hDEAD_BEEF;
  localparam int          READ_LAT     = 2;

endpackage

// File: rtl/normalizer_sp_ram.sv
// Single-port synchronous RAM with a registered read port, DEPTH x 32.
// Contents are not reset.
module normalizer_sp_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DEPTH];
  logic [31:0] q_r;

  // One access per cycle: write, or registered read into q_r
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
    if (re) begin
      q_r <= mem_r[addr];
    end
  end

  assign rdata = q_r;

endmodule

// File: rtl/normalizer_avs_mem.sv
// Avalon-MM responder for the normalizer DMA master: word-addressed sample buffer
// with programmable per-command stall and a fixed two-cycle pipelined read path.
module normalizer_avs_mem
  import normalizer_avs_mem_pkg::*;
#(
  parameter int          ADDR_W      = 8,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_CYCLES = 0,
  parameter int          MAX_PEND    = 2,
  parameter logic [31:0] OOR_DATA    = OOR_DATA_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] avs_s1_address,
  input  logic              avs_s1_read,
  input  logic              avs_s1_write,
  input  logic [31:0]       avs_s1_writedata,
  output logic              avs_s1_waitrequest,
  output logic              avs_s1_readdatavalid,
  output logic [31:0]       avs_s1_readdata,
  output logic              err_sticky
);

  localparam int         RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);
  localparam logic [1:0] PEND_L = 2'(MAX_PEND);

  state_t              state_r, state_nxt_s;
  logic [3:0]          cnt_r, cnt_nxt_s;
  logic [1:0]          pend_r;
  logic [READ_LAT-1:0] vpipe_r;
  logic                oor1_r;
  logic                err_r;
  logic [31:0]         rdata_r;
  logic [31:0]         q_s;
  logic                in_range_s;
  logic                cmd_s, rd_only_s, wait_s, acc_s, acc_rd_s, ram_we_s, bad_s;

  if (DEPTH >= (1 << ADDR_W)) begin : g_full_range
    assign in_range_s = 1'b1;
  end else begin : g_part_range
    assign in_range_s = ({1'b0, avs_s1_address} < (ADDR_W+1)'(DEPTH));
  end

  // Handshake: stall window, pending-read limit and acceptance qualifiers
  always_comb begin
    cmd_s     = avs_s1_read | avs_s1_write;
    rd_only_s = avs_s1_read & ~avs_s1_write;
    if (rst) begin
      wait_s = 1'b1;
    end else if (cmd_s) begin
      wait_s = (cnt_r != WAIT_L) || (rd_only_s && (pend_r == PEND_L));
    end else begin
      wait_s = 1'b0;
    end
    acc_s    = cmd_s & ~wait_s;
    acc_rd_s = acc_s & rd_only_s;
    ram_we_s = acc_s & avs_s1_write & in_range_s;
    bad_s    = acc_s & (~in_range_s | (avs_s1_read & avs_s1_write));
  end

  // Stall FSM: counter saturates at WAIT_CYCLES while the pending limit holds a read off
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_ACCEPT: begin
        if (cmd_s && (cnt_r != WAIT_L)) begin
          state_nxt_s = ST_STALL;
          cnt_nxt_s   = 4'd1;
        end else begin
          state_nxt_s = ST_ACCEPT;
          cnt_nxt_s   = 4'd0;
        end
      end
      ST_STALL: begin
        if (!cmd_s || acc_s) begin
          state_nxt_s = ST_ACCEPT;
          cnt_nxt_s   = 4'd0;
        end else if (cnt_r != WAIT_L) begin
          cnt_nxt_s = cnt_r + 4'd1;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        state_nxt_s = ST_ACCEPT;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // State, pending count, read-valid pipe, output data and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_ACCEPT;
      cnt_r   <= 4'd0;
      pend_r  <= 2'd0;
      vpipe_r <= '0;
      oor1_r  <= 1'b0;
      rdata_r <= 32'd0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (acc_rd_s && !vpipe_r[READ_LAT-1]) begin
        pend_r <= pend_r + 2'd1;
      end else if (!acc_rd_s && vpipe_r[READ_LAT-1]) begin
        pend_r <= pend_r - 2'd1;
      end else begin
        pend_r <= pend_r;
      end
      vpipe_r <= {vpipe_r[READ_LAT-2:0], acc_rd_s};
      oor1_r  <= acc_rd_s & ~in_range_s;
      if (vpipe_r[0]) begin
        rdata_r <= oor1_r ? OOR_DATA : q_s;
      end else begin
        rdata_r <= 32'd0;
      end
      if (bad_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  normalizer_sp_ram #(
    .DEPTH (DEPTH),
    .AW    (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .re    (acc_rd_s),
    .addr  (avs_s1_address[RAM_AW-1:0]),
    .wdata (avs_s1_writedata),
    .rdata (q_s)
  );

  assign avs_s1_waitrequest   = wait_s;
  assign avs_s1_readdatavalid = vpipe_r[READ_LAT-1];
  assign avs_s1_readdata      = rdata_r;
  assign err_sticky           = err_r;

endmodule

// File: tb/tb_normalizer_avs_mem.sv
// Scoreboard bench for normalizer_avs_mem: two instances (no stall / full depth,
// and 3-cycle stall / 200-word depth) driven one at a time against a reference model.
module tb_normalizer_avs_mem;

  localparam logic [31:0] OOR_WORD = 32'hDEAD_BEEF;
  localparam int          MAXP     = 2;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addr    [2];
  logic        rd      [2];
  logic        wr      [2];
  logic [31:0] wd      [2];
  logic        waitreq [2];
  logic        rdv     [2];
  logic        err     [2];
  logic [31:0] rdata   [2];

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_waits = 0;
  int          tot;
  bit          cur = 1'b0;
  int          depth_m [2];
  int          waitc_m [2];
  bit          err_m   [2];
  logic [31:0] mem_m   [2][256];
  exp_t        expq [$];
  int          accq [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  normalizer_avs_mem #(.ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0), .MAX_PEND(2)) dut0 (
    .clk(clk), .rst(rst), .avs_s1_address(addr[0]), .avs_s1_read(rd[0]),
    .avs_s1_write(wr[0]), .avs_s1_writedata(wd[0]), .avs_s1_waitrequest(waitreq[0]),
    .avs_s1_readdatavalid(rdv[0]), .avs_s1_readdata(rdata[0]), .err_sticky(err[0]));

  normalizer_avs_mem #(.ADDR_W(8), .DEPTH(200), .WAIT_CYCLES(3), .MAX_PEND(2)) dut1 (
    .clk(clk), .rst(rst), .avs_s1_address(addr[1]), .avs_s1_read(rd[1]),
    .avs_s1_write(wr[1]), .avs_s1_writedata(wd[1]), .avs_s1_waitrequest(waitreq[1]),
    .avs_s1_readdatavalid(rdv[1]), .avs_s1_readdata(rdata[1]), .err_sticky(err[1]));

  task automatic chk_w(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: dut%0d got %h expected %h at cycle %0d", nm, cur, act, exp, cyc);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: dut%0d got %b expected %b at cycle %0d", nm, cur, act, exp, cyc);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: dut%0d got %0d expected %0d at cycle %0d", nm, cur, act, exp, cyc);
    end
  endtask

  // Response monitor: pops the scoreboard whenever a DUT presents readdatavalid
  task automatic mon(input bit d);
    exp_t e;
    if (rdv[d]) begin
      if (d != cur || expq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rdv: dut%0d readdatavalid high at cycle %0d", d, cyc);
      end else begin
        e = expq.pop_front();
        chk_w("readdata", rdata[d], e.data);
        chk_i("rdv_cycle", cyc, e.cyc);
      end
    end else begin
      chk_w("rdata_idle", rdata[d], 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(1'b0);
      mon(1'b1);
    end
  end

  // Present one command on the current DUT until accepted; update the model
  task automatic issue(input bit r, input bit w, input logic [7:0] a, input logic [31:0] dt);
    bit ok = 1'b0;
    bit exp_w;
    int ai = int'(a);
    rd[cur] = r; wr[cur] = w; addr[cur] = a; wd[cur] = dt;
    last_waits = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      while (accq.size() > 0 && accq[0] + 2 < cyc) void'(accq.pop_front());
      exp_w = (k < waitc_m[cur]) || (r && !w && accq.size() == MAXP);
      chk_b("waitrequest", waitreq[cur], exp_w);
      if (!waitreq[cur]) begin
        ok = 1'b1;
        break;
      end
      last_waits++;
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: dut%0d address %h never accepted", cur, a);
      rd[cur] = 1'b0; wr[cur] = 1'b0;
    end else if (w) begin
      if (ai < depth_m[cur]) mem_m[cur][a] = dt;
      else err_m[cur] = 1'b1;
      if (r) err_m[cur] = 1'b1;
    end else begin
      if (ai < depth_m[cur]) expq.push_back('{mem_m[cur][a], cyc + 2});
      else begin
        expq.push_back('{OOR_WORD, cyc + 2});
        err_m[cur] = 1'b1;
      end
      accq.push_back(cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    rd[cur] = 1'b0; wr[cur] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle(1);
    for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
    #1;
    chk_i("drain_outstanding", expq.size(), 0);
  endtask

  task automatic fill();
    for (int i = 0; i < depth_m[cur]; i++) issue(1'b0, 1'b1, 8'(i), $urandom);
    idle(1);
  endtask

  task automatic rand_ops(input int n);
    int op;
    for (int i = 0; i < n; i++) begin
      op = $urandom_range(0, 3);
      issue(op >= 2, op < 2, 8'($urandom_range(0, 255)), $urandom);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    drain();
    chk_b("err_sticky_rand", err[cur], err_m[cur]);
  endtask

  initial begin
    depth_m[0] = 256; depth_m[1] = 200;
    waitc_m[0] = 0;   waitc_m[1] = 3;
    err_m[0] = 1'b0;  err_m[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = 8'd0; wd[d] = 32'd0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_b("wait_in_reset", waitreq[0], 1'b1);
    chk_b("wait_in_reset1", waitreq[1], 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_b("wait_idle", waitreq[0], 1'b0);
    chk_b("wait_idle1", waitreq[1], 1'b0);
    chk_b("err_reset", err[0], 1'b0);
    chk_b("rdv_reset", rdv[0], 1'b0);
    @(posedge clk); #1;

    // Instance 0: no stall, full depth
    cur = 1'b0;
    issue(1'b0, 1'b1, 8'h05, 32'h1234_5678);
    chk_i("t1_write_waits", last_waits, 0);
    issue(1'b1, 1'b0, 8'h05, 32'd0);
    chk_i("t1_read_waits", last_waits, 0);
    drain();
    fill();
    rand_ops(120);
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b0, 8'(i), 32'd0);
      tot += last_waits;
    end
    chk_i("t3_pend_stalls", tot, 1);
    issue(1'b0, 1'b1, 8'h40, 32'hCAFE_0040);
    issue(1'b1, 1'b0, 8'h40, 32'd0);
    drain();
    chk_b("t5_err_before", err[0], 1'b0);
    issue(1'b1, 1'b1, 8'h10, 32'hA5A5_1010);
    idle(4);
    chk_b("t5_err_after", err[0], 1'b1);
    issue(1'b1, 1'b0, 8'h10, 32'd0);
    drain();

    issue(1'b1, 1'b0, 8'h22, 32'd0);
    rst = 1'b1; rd[0] = 1'b0;
    expq.delete(); accq.delete();
    err_m[0] = 1'b0; err_m[1] = 1'b0;
    @(negedge clk);
    chk_b("t6_wait_in_reset", waitreq[0], 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(4);
    chk_b("t6_err_cleared", err[0], 1'b0);
    tot = 0;
    for (int i = 1; i < 4; i++) begin
      issue(1'b1, 1'b0, 8'(i), 32'd0);
      tot += last_waits;
    end
    chk_i("t6_post_reset_stalls", tot, 1);
    drain();

    // Instance 1: 3-cycle stall, 200 words
    cur = 1'b1;
    fill();
    issue(1'b1, 1'b0, 8'h05, 32'd0);
    chk_i("t2_stall_waits", last_waits, 3);
    drain();
    chk_b("t4_err_before", err[1], 1'b0);
    issue(1'b0, 1'b1, 8'hC8, 32'h0BAD_F00D);
    issue(1'b1, 1'b0, 8'hC8, 32'd0);
    issue(1'b1, 1'b0, 8'hC7, 32'd0);
    drain();
    chk_b("t4_err_after", err[1], 1'b1);
    rand_ops(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
